// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU datapath slice: the default widths used
//   by the 4-bit adder and by the summing stage that consumes its result,
//   and the state encoding of the summing stage's two-state FSM.
//
//   Contents:
//     DEF_SUM_W  default width of the adder sum bus
//     DEF_ACC_W  default width of the frame accumulator / result
//     ST_ACCUM   summing stage collecting samples
//     ST_HOLD    summing stage presenting a finished frame total
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int DEF_SUM_W = 4;
   localparam int DEF_ACC_W = 8;

   // Plain constants rather than an enum so that older blocks sharing this
   // package can keep treating the state as a bare bit vector.
   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage : alu_pkg

// File: rtl/sum_accum_stage.sv
// ---------------------------------------------------------------------------
// sum_accum_stage
//   Framed accumulator behind the adder. Each accepted adder result
//   {cout,sum} is zero-extended and added into an ACC_W-bit total. After
//   N_SAMPLES accepts, the total is held and offered on a valid/ready
//   handshake together with a sticky overflow flag. The consumer taking
//   the total clears the frame and reopens the input.
//
//   Parameters:
//     SUM_W      width of the adder sum input
//     ACC_W      accumulator / result width (>= SUM_W+1)
//     N_SAMPLES  samples per frame (>= 1)
//     CNT_W      sample counter width, derived from N_SAMPLES
//
//   Ports:
//     clk        in   clock, all state on the rising edge
//     rst_n      in   asynchronous active-low reset
//     clr        in   synchronous frame abort; beats both handshakes
//     in_valid   in   adder result valid this cycle
//     in_ready   out  stage can accept a sample (state decode only)
//     sum        in   adder sum
//     cout       in   adder carry out
//     out_valid  out  frame total available (state decode only)
//     out_ready  in   consumer takes the total
//     acc_out    out  frame total modulo 2^ACC_W
//     ovf        out  sticky: the frame total wrapped past 2^ACC_W-1
//     count      out  samples accepted in the current frame
// ---------------------------------------------------------------------------
module sum_accum_stage
   import alu_pkg::*;
#(
   parameter int SUM_W     = DEF_SUM_W,
   parameter int ACC_W     = DEF_ACC_W,
   parameter int N_SAMPLES = 4,
   parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SUM_W-1:0] sum,
   input  logic             cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf,
   output logic [CNT_W-1:0] count
);

   logic [0:0]     state;
   logic [ACC_W:0] sample_ext;   // one bit wider than acc to catch the carry
   logic [ACC_W:0] add_full;
   logic           last_sample;

   // Both handshake signals depend on state alone, so neither in_valid nor
   // out_ready has a combinational path to an output.
   assign in_ready  = (state == ST_ACCUM);
   assign out_valid = (state == ST_HOLD);

   // NOTE: every signal driven in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      sample_ext            = '0;
      sample_ext[SUM_W:0]   = {cout, sum};
   end

   // Bit ACC_W of the widened add is the carry out of the accumulator MSB.
   assign add_full    = {1'b0, acc_out} + sample_ext;
   assign last_sample = (count == CNT_W'(N_SAMPLES - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement
   // order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_ACCUM;
         acc_out <= '0;
         ovf     <= 1'b0;
         count   <= '0;
      end else if (clr) begin
         // Abort: drop any sample or handshake presented on this edge.
         state   <= ST_ACCUM;
         acc_out <= '0;
         ovf     <= 1'b0;
         count   <= '0;
      end else if (state == ST_HOLD) begin
         // Results stay frozen until the consumer takes them; in_valid is
         // ignored here because in_ready is low.
         if (out_ready) begin
            state   <= ST_ACCUM;
            acc_out <= '0;
            ovf     <= 1'b0;
            count   <= '0;
         end
      end else if (in_valid) begin
         acc_out <= add_full[ACC_W-1:0];
         ovf     <= ovf | add_full[ACC_W];
         count   <= count + CNT_W'(1);
         if (last_sample) begin
            state <= ST_HOLD;
         end
      end
   end

endmodule : sum_accum_stage

// File: tb/tb_sum_accum_stage.sv
// ---------------------------------------------------------------------------
// tb_sum_accum_stage
//   Two instances share clk/rst_n: dut_a uses the default frame of 4
//   samples, dut_b a frame of 16 samples for the wrap-around case.
//   Expected values come from constants and from a frame model that keeps
//   the running total as a plain integer.
// ---------------------------------------------------------------------------
module tb_sum_accum_stage;

   localparam int N_A  = 4;
   localparam int N_B  = 16;
   localparam int CW_A = $clog2(N_A + 1);
   localparam int CW_B = $clog2(N_B + 1);

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic            a_clr, a_in_valid, a_cout, a_out_ready;
   logic [3:0]      a_sum;
   logic            a_in_ready, a_out_valid, a_ovf;
   logic [7:0]      a_acc;
   logic [CW_A-1:0] a_count;

   logic            b_clr, b_in_valid, b_cout, b_out_ready;
   logic [3:0]      b_sum;
   logic            b_in_ready, b_out_valid, b_ovf;
   logic [7:0]      b_acc;
   logic [CW_B-1:0] b_count;

   int n_cmp = 0;
   int n_bad = 0;

   sum_accum_stage #(.SUM_W(4), .ACC_W(8), .N_SAMPLES(N_A)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (a_clr),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .sum       (a_sum),
      .cout      (a_cout),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .acc_out   (a_acc),
      .ovf       (a_ovf),
      .count     (a_count)
   );

   sum_accum_stage #(.SUM_W(4), .ACC_W(8), .N_SAMPLES(N_B)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (b_clr),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .sum       (b_sum),
      .cout      (b_cout),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .acc_out   (b_acc),
      .ovf       (b_ovf),
      .count     (b_count)
   );

   // Advance one clock; outputs are read 1 ns after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [4:0] val,
                          input logic ordy, input logic c);
      a_in_valid  = v;
      a_cout      = val[4];
      a_sum       = val[3:0];
      a_out_ready = ordy;
      a_clr       = c;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b1;
      drive_a(1'b0, 5'd0, 1'b0, 1'b0);
      b_in_valid = 1'b0; b_sum = '0; b_cout = 1'b0; b_out_ready = 1'b0; b_clr = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_out_valid, a_in_ready, a_ovf, a_acc, a_count} !== {1'b0, 1'b1, 1'b0, 8'd0, 3'd0}) begin
         n_bad++;
         $display("FAIL reset_initial: got ov=%b ir=%b ovf=%b acc=%0d cnt=%0d, want 0 1 0 0 0",
                  a_out_valid, a_in_ready, a_ovf, a_acc, a_count);
      end
      cyc(); cyc();
      @(negedge clk) rst_n = 1'b1;
      cyc();
      // two samples: 3 + 5
      drive_a(1'b1, 5'd3, 1'b0, 1'b0); cyc();
      drive_a(1'b1, 5'd5, 1'b0, 1'b0); cyc();
      drive_a(1'b0, 5'd0, 1'b0, 1'b0);
      n_cmp++;
      if (a_acc !== 8'd8 || a_count !== 3'd2) begin
         n_bad++;
         $display("FAIL reset_preload: got acc=%0d cnt=%0d, want 8 2", a_acc, a_count);
      end
      // reset mid-cycle, no clock edge in between
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_out_valid, a_in_ready, a_ovf, a_acc, a_count} !== {1'b0, 1'b1, 1'b0, 8'd0, 3'd0}) begin
         n_bad++;
         $display("FAIL reset_async: got ov=%b ir=%b ovf=%b acc=%0d cnt=%0d, want 0 1 0 0 0",
                  a_out_valid, a_in_ready, a_ovf, a_acc, a_count);
      end
      cyc();
      @(negedge clk) rst_n = 1'b1;
      cyc();
   endtask

   // ------------------------------------------------------------------
   task automatic test_basic_frame();
      logic [4:0] vals [4];
      int exp_total;
      vals = '{5'b0_0011, 5'b0_0101, 5'b1_1010, 5'b0_0001};
      exp_total = 0;
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, vals[i], 1'b0, 1'b0);
         cyc();
         exp_total += vals[i];
         n_cmp++;
         if (a_count !== CW_A'(i + 1) || a_acc !== 8'(exp_total) || a_out_valid !== (i == 3)) begin
            n_bad++;
            $display("FAIL basic_step%0d: got cnt=%0d acc=%0d ov=%b, want %0d %0d %b",
                     i, a_count, a_acc, a_out_valid, i + 1, exp_total, (i == 3));
         end
      end
      n_cmp++;
      if ({a_out_valid, a_in_ready, a_ovf, a_acc, a_count} !== {1'b1, 1'b0, 1'b0, 8'd35, 3'd4}) begin
         n_bad++;
         $display("FAIL basic_total: got ov=%b ir=%b ovf=%b acc=%0d cnt=%0d, want 1 0 0 35 4",
                  a_out_valid, a_in_ready, a_ovf, a_acc, a_count);
      end
      // consumer stalls; input keeps offering samples that must be ignored
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b1, 5'd7, 1'b0, 1'b0);
         cyc();
         n_cmp++;
         if ({a_out_valid, a_in_ready, a_acc, a_count} !== {1'b1, 1'b0, 8'd35, 3'd4}) begin
            n_bad++;
            $display("FAIL basic_hold%0d: got ov=%b ir=%b acc=%0d cnt=%0d, want 1 0 35 4",
                     i, a_out_valid, a_in_ready, a_acc, a_count);
         end
      end
      drive_a(1'b0, 5'd0, 1'b1, 1'b0);
      cyc();
      drive_a(1'b0, 5'd0, 1'b0, 1'b0);
      n_cmp++;
      if ({a_out_valid, a_in_ready, a_ovf, a_acc, a_count} !== {1'b0, 1'b1, 1'b0, 8'd0, 3'd0}) begin
         n_bad++;
         $display("FAIL basic_release: got ov=%b ir=%b ovf=%b acc=%0d cnt=%0d, want 0 1 0 0 0",
                  a_out_valid, a_in_ready, a_ovf, a_acc, a_count);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_overflow();
      b_in_valid = 1'b1; b_sum = 4'hF; b_cout = 1'b1; b_out_ready = 1'b0; b_clr = 1'b0;
      for (int i = 1; i <= N_B; i++) begin
         cyc();
         if (i == 8 || i == 9) begin
            n_cmp++;
            if (b_ovf !== (i * 31 > 255) || b_acc !== 8'((i * 31) % 256)) begin
               n_bad++;
               $display("FAIL ovf_step%0d: got ovf=%b acc=%0d, want %b %0d",
                        i, b_ovf, b_acc, (i * 31 > 255), (i * 31) % 256);
            end
         end
      end
      b_in_valid = 1'b0;
      n_cmp++;
      if ({b_out_valid, b_ovf, b_acc, b_count} !== {1'b1, 1'b1, 8'd240, 5'd16}) begin
         n_bad++;
         $display("FAIL ovf_total: got ov=%b ovf=%b acc=%0d cnt=%0d, want 1 1 240 16",
                  b_out_valid, b_ovf, b_acc, b_count);
      end
      b_out_ready = 1'b1;
      cyc();
      b_out_ready = 1'b0;
      n_cmp++;
      if ({b_out_valid, b_ovf, b_acc, b_count} !== {1'b0, 1'b0, 8'd0, 5'd0}) begin
         n_bad++;
         $display("FAIL ovf_release: got ov=%b ovf=%b acc=%0d cnt=%0d, want 0 0 0 0",
                  b_out_valid, b_ovf, b_acc, b_count);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_gaps();
      int accepted = 0;
      for (int i = 0; i < 8; i++) begin
         drive_a((i % 2) == 0, 5'd1, 1'b0, 1'b0);
         cyc();
         if ((i % 2) == 0) accepted++;
         n_cmp++;
         if (a_count !== CW_A'(accepted) || a_acc !== 8'(accepted) || a_out_valid !== (accepted == 4)) begin
            n_bad++;
            $display("FAIL gaps_cyc%0d: got cnt=%0d acc=%0d ov=%b, want %0d %0d %b",
                     i, a_count, a_acc, a_out_valid, accepted, accepted, (accepted == 4));
         end
      end
      drive_a(1'b0, 5'd0, 1'b1, 1'b0);
      cyc();
      drive_a(1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   // ------------------------------------------------------------------
   task automatic test_clr();
      // abort on the edge carrying the 4th sample
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b1, 5'd9, 1'b0, 1'b0); cyc();
      end
      drive_a(1'b1, 5'd9, 1'b0, 1'b1); cyc();
      drive_a(1'b0, 5'd0, 1'b0, 1'b0);
      n_cmp++;
      if ({a_out_valid, a_in_ready, a_ovf, a_acc, a_count} !== {1'b0, 1'b1, 1'b0, 8'd0, 3'd0}) begin
         n_bad++;
         $display("FAIL clr_last_sample: got ov=%b ir=%b ovf=%b acc=%0d cnt=%0d, want 0 1 0 0 0",
                  a_out_valid, a_in_ready, a_ovf, a_acc, a_count);
      end
      cyc();
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_count !== 3'd0) begin
         n_bad++;
         $display("FAIL clr_no_frame: got ov=%b cnt=%0d, want 0 0", a_out_valid, a_count);
      end
      // abort in HOLD together with the output handshake
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, 5'd31, 1'b0, 1'b0); cyc();
      end
      n_cmp++;
      if ({a_out_valid, a_acc, a_count} !== {1'b1, 8'd124, 3'd4}) begin
         n_bad++;
         $display("FAIL clr_prefill: got ov=%b acc=%0d cnt=%0d, want 1 124 4", a_out_valid, a_acc, a_count);
      end
      drive_a(1'b1, 5'd31, 1'b1, 1'b1); cyc();
      drive_a(1'b0, 5'd0, 1'b0, 1'b0);
      n_cmp++;
      if ({a_out_valid, a_in_ready, a_ovf, a_acc, a_count} !== {1'b0, 1'b1, 1'b0, 8'd0, 3'd0}) begin
         n_bad++;
         $display("FAIL clr_in_hold: got ov=%b ir=%b ovf=%b acc=%0d cnt=%0d, want 0 1 0 0 0",
                  a_out_valid, a_in_ready, a_ovf, a_acc, a_count);
      end
   endtask

   // ------------------------------------------------------------------
   // Release at edge h with in_valid already high: that edge ignores the
   // sample, the next edge takes it as the first of the new frame.
   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b1, 5'd2, 1'b0, 1'b0); cyc();
      end
      drive_a(1'b1, 5'd6, 1'b1, 1'b0); cyc();
      n_cmp++;
      if ({a_out_valid, a_in_ready, a_acc, a_count} !== {1'b0, 1'b1, 8'd0, 3'd0}) begin
         n_bad++;
         $display("FAIL b2b_release: got ov=%b ir=%b acc=%0d cnt=%0d, want 0 1 0 0",
                  a_out_valid, a_in_ready, a_acc, a_count);
      end
      drive_a(1'b1, 5'd6, 1'b0, 1'b0); cyc();
      drive_a(1'b0, 5'd0, 1'b0, 1'b0);
      n_cmp++;
      if (a_acc !== 8'd6 || a_count !== 3'd1) begin
         n_bad++;
         $display("FAIL b2b_first: got acc=%0d cnt=%0d, want 6 1", a_acc, a_count);
      end
      drive_a(1'b0, 5'd0, 1'b0, 1'b1); cyc();
      drive_a(1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   // ------------------------------------------------------------------
   // Random traffic against a frame model: running total as an integer,
   // number of samples taken, and whether the frame is complete.
   task automatic test_random();
      int  m_total = 0;
      int  m_cnt   = 0;
      bit  m_full  = 0;
      logic v, r, c;
      logic [4:0] val;
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         r   = ($urandom_range(0, 2) == 0);
         c   = ($urandom_range(0, 39) == 0);
         val = 5'($urandom_range(0, 31));
         drive_a(v, val, r, c);
         if (c) begin
            m_total = 0; m_cnt = 0; m_full = 0;
         end else if (m_full) begin
            if (r) begin
               m_total = 0; m_cnt = 0; m_full = 0;
            end
         end else if (v) begin
            m_total += int'(val);
            m_cnt++;
            m_full = (m_cnt == N_A);
         end
         cyc();
         n_cmp++;
         if (a_out_valid !== m_full || a_in_ready !== !m_full || a_acc !== 8'(m_total % 256) ||
             a_ovf !== (m_total > 255) || a_count !== CW_A'(m_cnt)) begin
            n_bad++;
            $display("FAIL random_cyc%0d: got ov=%b ir=%b acc=%0d ovf=%b cnt=%0d, want %b %b %0d %b %0d",
                     i, a_out_valid, a_in_ready, a_acc, a_ovf, a_count,
                     m_full, !m_full, m_total % 256, (m_total > 255), m_cnt);
         end
      end
      drive_a(1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_overflow();
      test_gaps();
      test_clr();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_sum_accum_stage
